rx_byte_fifo: RTL and testbench

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures every byte the receiver presents with its one-cycle `load` strobe and stores it in a power-of-two circular buffer. Bytes are handed to the consumer (command parser / bus bridge) over a first-word-fall-through valid/ready interface. Drops on a full buffer are reported with a sticky overflow flag, so bursts at 921600 baud are absorbed without loss while the consumer stalls.

---
 rtl/rx_byte_fifo.sv | 113 +++++++++++
 tb/tb_rx_byte_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: receive-side byte buffer behind the UART receiver.
// Bytes strobed in with `load` go into a power-of-two circular buffer and
// leave through a first-word-fall-through valid/ready port. Bytes arriving
// while the buffer is full (and nothing is popped) are dropped and reported
// through a sticky overflow flag.
module rx_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] RxData,
    input  logic              load,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              full_s, empty_s;
    logic              push_s, pop_s, drop_s;

    // Occupancy flags decode straight from the registered count.
    assign full_s  = (count_q == FULL_CNT);
    assign empty_s = (count_q == {(ADDR_W + 1){1'b0}});

    // Handshake decode and next-state for pointers, count and overflow.
    always_comb begin
        pop_s      = !empty_s && rd_ready;
        push_s     = load && (!full_s || pop_s);
        drop_s     = load && full_s && !pop_s;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            count_q    <= {(ADDR_W + 1){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; cleared on reset so a stale byte never reads back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= RxData;
        end
    end

    // Outputs all derive from registers; rd_ready only affects next state.
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = !empty_s;
    assign count    = count_q;
    assign full     = full_s;
    assign empty    = empty_s;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed, self-checking bench for rx_byte_fifo (DATA_W=8, DEPTH=16).
module tb_rx_byte_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] RxData;
    logic       load;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       ld;
        logic [7:0] din;
        logic       rr;
        logic       clr;
        logic [4:0] e_cnt;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    rx_byte_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .RxData       (RxData),
        .load         (load),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, and sample 1 time unit after the edge.
    task automatic step(input logic ld, input logic [7:0] d, input logic rr, input logic clr);
        load = ld; RxData = d; rd_ready = rr; clr_overflow = clr;
        @(posedge clk);
        #1;
        load = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0; RxData = 8'h00;
    endtask

    task automatic check_state(input string tag, input logic [4:0] cnt, input logic valid,
                               input logic [7:0] data, input logic fl, input logic ovf);
        chk({tag, ".count"},    32'(count),    32'(cnt));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(valid));
        chk({tag, ".empty"},    32'(empty),    32'(cnt == 5'd0));
        chk({tag, ".full"},     32'(full),     32'(fl));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
        if (valid) chk({tag, ".rd_data"}, 32'(rd_data), 32'(data));
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; RxData = 8'h00; rd_ready = 1'b0; clr_overflow = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Reset state, including the cleared array word under rd_ptr.
        check_state("reset", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset.rd_data", 32'(rd_data), 32'h0);
        reset = 1'b0;

        // Basic push / in-order pop table.
        vecs.push_back('{1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 1'b1, 8'h41, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h42, 1'b0, 1'b0, 5'd2, 1'b1, 8'h41, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h43, 1'b0, 1'b0, 5'd3, 1'b1, 8'h41, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 1'b1, 8'h42, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 8'h43, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0});
        // rd_ready while empty must not underflow.
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0});
        // Load plus ready on empty: push only, byte falls through.
        vecs.push_back('{1'b1, 8'h5A, 1'b1, 1'b0, 5'd1, 1'b1, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0});
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ld, vecs[i].din, vecs[i].rr, vecs[i].clr);
            check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_valid,
                        vecs[i].e_data, vecs[i].e_full, vecs[i].e_ovf);
        end

        // Fill to full, then drop 0xAA.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            chk($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
        end
        check_state("full", 5'd16, 1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check_state("drop", 5'd16, 1'b1, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.rd_data", i), 32'(rd_data), 32'(i));
            chk($sformatf("drain%0d.rd_valid", i), 32'(rd_valid), 32'h1);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_state("drained", 5'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr.overflow", 32'(overflow), 32'h0);

        // Full with simultaneous load and pop: no drop, 0x55 comes out last.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check_state("fullpp", 5'd16, 1'b1, 8'h11, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pp%0d.rd_data", i), 32'(rd_data), (i == 15) ? 32'h55 : 32'(8'h11 + i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_state("ppdrained", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Wrap-around streaming: 40 push/pop pairs.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            chk($sformatf("wrap%0d.rd_data", i), 32'(rd_data), 32'(8'h80 + i));
            chk($sformatf("wrap%0d.count", i), 32'(count), 32'h1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("wrapend", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Overflow set beats a coinciding clear.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf.set", 32'(overflow), 32'h1);
        step(1'b1, 8'hEF, 1'b0, 1'b1);
        check_state("ovf.setwins", 5'd16, 1'b1, 8'hC0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf.clear", 32'(overflow), 32'h0);

        // Asynchronous reset mid-cycle with 5 bytes stored.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        chk("pre_arst.count", 32'(count), 32'h5);
        #3;
        reset = 1'b1;
        #1;
        check_state("arst", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("arst.rd_data", 32'(rd_data), 32'h0);
        load = 1'b1; RxData = 8'h99;
        @(posedge clk); #1;
        chk("arst_load.count", 32'(count), 32'h0);
        load = 1'b0; reset = 1'b0;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        check_state("post_rst", 5'd1, 1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("post_rst_pop", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
